// File: rtl/dma_read_master.sv
// AXI4 read-side DMA engine: splits a byte-length transfer into 4 KB-safe INCR
// bursts, one outstanding at a time, and streams returned beats into a FIFO.
module dma_read_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_MAX_BURST_LEN    = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            i_start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   i_src_addr,
  input  logic [31:0]                     i_total_len,
  output logic                            o_busy,
  output logic                            o_read_done,
  output logic                            o_read_err,
  input  logic                            i_fifo_full,
  output logic                            o_fifo_wr_en,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   o_fifo_wdata,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]                      m_axi_arlen,
  output logic [2:0]                      m_axi_arsize,
  output logic [1:0]                      m_axi_arburst,
  output logic                            m_axi_arvalid,
  input  logic                            m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                      m_axi_rresp,
  input  logic                            m_axi_rlast,
  input  logic                            m_axi_rvalid,
  output logic                            m_axi_rready
);

  localparam logic [31:0] MAX_BURST = 32'(C_MAX_BURST_LEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_DONE
  } state_t;

  state_t                          state_q;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [31:0]                     beats_left_q;
  logic [8:0]                      burst_q;
  logic [7:0]                      arlen_q;
  logic                            arvalid_q;
  logic                            busy_q;
  logic                            done_q;
  logic                            err_q;

  logic [31:0]                     start_beats;
  logic [8:0]                      start_burst;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   next_addr;
  logic [31:0]                     next_beats;
  logic [8:0]                      next_burst;
  logic                            r_hs;
  logic                            unused_len_bits;

  // Beats in the next burst: limited by what is left, the burst cap, and the
  // distance to the next 4 KB page so no burst straddles a page boundary.
  function automatic logic [8:0] calc_burst(input logic [11:0] page_off,
                                            input logic [31:0] beats);
    logic [31:0] to_boundary;
    logic [31:0] b;
    to_boundary = (32'd4096 - {20'd0, page_off}) >> 2;
    b = beats;
    if (b > MAX_BURST)   b = MAX_BURST;
    if (b > to_boundary) b = to_boundary;
    return b[8:0];
  endfunction

  assign unused_len_bits = ^i_total_len[1:0];
  assign start_beats     = {2'b00, i_total_len[31:2]};
  assign start_burst     = calc_burst(i_src_addr[11:0], start_beats);
  assign next_addr       = addr_q + C_M_AXI_ADDR_WIDTH'({burst_q, 2'b00});
  assign next_beats      = beats_left_q - 32'(burst_q);
  assign next_burst      = calc_burst(next_addr[11:0], next_beats);

  // Backpressure goes straight onto RREADY so a full FIFO stalls the slave
  // in the same cycle instead of dropping a beat.
  assign m_axi_rready  = (state_q == S_R) && !i_fifo_full;
  assign r_hs          = m_axi_rvalid && m_axi_rready;
  assign o_fifo_wr_en  = r_hs;
  assign o_fifo_wdata  = m_axi_rdata;

  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arsize  = 3'b010;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arvalid = arvalid_q;
  assign o_busy        = busy_q;
  assign o_read_done   = done_q;
  assign o_read_err    = err_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      beats_left_q <= '0;
      burst_q      <= '0;
      arlen_q      <= '0;
      arvalid_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            addr_q       <= i_src_addr;
            beats_left_q <= start_beats;
            err_q        <= 1'b0;
            busy_q       <= 1'b1;
            if (start_beats == 32'd0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= S_AR;
              arvalid_q <= 1'b1;
              burst_q   <= start_burst;
              arlen_q   <= 8'(start_burst - 9'd1);
            end
          end
        end

        S_AR: begin
          if (m_axi_arready) begin
            arvalid_q <= 1'b0;
            state_q   <= S_R;
          end
        end

        S_R: begin
          if (r_hs) begin
            if (m_axi_rresp != 2'b00) err_q <= 1'b1;
            if (m_axi_rlast) begin
              addr_q       <= next_addr;
              beats_left_q <= next_beats;
              if (next_beats == 32'd0) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q   <= S_AR;
                arvalid_q <= 1'b1;
                burst_q   <= next_burst;
                arlen_q   <= 8'(next_burst - 9'd1);
              end
            end
          end
        end

        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/dma_read_master.md
# dma_read_master

AXI4 read-side engine of the DMA: on a start pulse it reads `i_total_len` bytes from `i_src_addr` as a sequence of INCR bursts and pushes every returned word into the shared data FIFO. That FIFO is drained by the write master. FIFO-full backpressure is applied directly on RREADY, so no data is ever dropped. One burst is outstanding at a time; completion is signalled by a one-cycle done pulse.

## Interface
- C_M_AXI_ADDR_WIDTH, 32, address width
- C_M_AXI_DATA_WIDTH, 32, data width (only 32 supported; beat = 4 bytes)
- C_MAX_BURST_LEN, 16, maximum beats per burst (1..256)

Ports:
- clk  in  1  single clock, all logic rising-edge
- reset  in  1  synchronous, active-high reset
- i_start  in  1  one-cycle start pulse; ignored unless idle
- i_src_addr  in  32  source byte address, word aligned; sampled on accepted start
- i_total_len  in  32  transfer length in bytes, sampled on accepted start; bits [1:0] ignored
- o_busy  out  1  high from accepted start until the done pulse, inclusive
- o_read_done  out  1  one-cycle completion pulse
- o_read_err  out  1  sticky: some beat returned RRESP != OKAY; cleared on accepted start
- i_fifo_full  in  1  FIFO cannot accept a write this cycle
- o_fifo_wr_en  out  1  push o_fifo_wdata this cycle
- o_fifo_wdata  out  32  data to FIFO
- m_axi_araddr  out  32  burst start address
- m_axi_arlen  out  8  beats − 1
- m_axi_arsize  out  3  constant 3'b010
- m_axi_arburst  out  2  constant 2'b01 (INCR)
- m_axi_arvalid  out  1  AR valid
- m_axi_arready  in  1  AR ready
- m_axi_rdata  in  32  read data
- m_axi_rresp  in  2  read response
- m_axi_rlast  in  1  last beat of burst
- m_axi_rvalid  in  1  R valid
- m_axi_rready  out  1  R ready

## Operation
- States are IDLE, AR, R and DONE.
- IDLE:
  - The block accepts i_start only in IDLE.
  - On accept it latches addr = i_src_addr and beats_left = i_total_len >> 2, and clears o_read_err.
  - It then goes to AR, or to DONE if beats_left == 0.
- AR:
  - burst = min(beats_left, C_MAX_BURST_LEN, (4096 − addr[11:0]) >> 2), so no burst crosses a 4 KB boundary.
  - arlen = burst − 1. arvalid is held high with araddr/arlen stable until arready.
  - On handshake the block goes to R.
- R:
  - m_axi_rready = !i_fifo_full (combinational).
  - o_fifo_wr_en = rvalid && rready, with o_fifo_wdata = rdata (combinational pass-through).
  - On each beat handshake with rresp != 2'b00, o_read_err is set.
  - On the handshake with rlast high: addr += burst×4 and beats_left −= burst. The block goes to DONE if beats_left is now 0, otherwise to AR.
- DONE: o_read_done = 1 for exactly one cycle, then IDLE.
- Address arithmetic is 32-bit and wraps modulo 2^32; no error is flagged on wrap.
- The burst length is computed with 32-bit intermediates; arlen truncates to 8 bits. This is safe because burst ≤ C_MAX_BURST_LEN.
- An i_start asserted while busy is ignored and does not disturb the transfer.

## Timing
- Reset values:
  - m_axi_arvalid=0, m_axi_araddr=0, m_axi_arlen=0.
  - m_axi_rready=0 (forced low outside R).
  - o_fifo_wr_en=0, o_busy=0, o_read_done=0, o_read_err=0, state=IDLE.
- Start to m_axi_arvalid is 1 cycle: start is sampled at edge N and arvalid is high after edge N.
- The AR handshake is followed by rready being eligible in the next cycle.
- Back-to-back bursts: after the rlast handshake, arvalid for the next burst rises the following cycle.
- Done latency: the last rlast handshake is followed by o_read_done high in the next cycle.
- For a zero-length start, o_read_done is high in the cycle after start.
- FIFO backpressure:
  - An i_fifo_full edge takes effect on rready in the same cycle.
  - No FIFO write occurs while full.
  - Beat order is preserved, with no duplicated or lost words.
- Reset asserted mid-transfer returns the block to the reset values on the next edge. The in-flight AXI transaction is abandoned, and the interconnect is reset by the same system reset.

## Test plan
- 64 B from 0x1000_0000, slave AR delay 2, RVALID always:
  - one AR with araddr 0x1000_0000, arlen 15;
  - 16 FIFO writes in order;
  - o_read_done 1 cycle after the rlast handshake; o_busy low afterwards.
- 128 B from 0x1000_1000: two ARs (0x1000_1000 and 0x1000_1040), each arlen 15; 32 FIFO writes; exactly one done pulse.
- 4 KB crossing, 64 B from 0x0000_0FF0: first AR at 0x0FF0 with arlen 3, second AR at 0x1000 with arlen 11; 16 writes.
- FIFO full for 20 cycles after the 4th beat of a 64 B transfer:
  - rready low and no wr_en throughout;
  - the transfer resumes with all 16 words delivered exactly once in order.
- Zero length: o_read_done one cycle after start; arvalid never asserted.
- Error, reset and busy-start:
  - rresp=2'b10 on beat 5: o_read_err set, the transfer still completes, and the flag clears on the next start.
  - Reset during beat 8: all outputs at reset values the next cycle.
  - A start issued while busy is ignored.
